// File: rtl/pulse_frontend.sv
// Per-channel pulse conditioning: polarity, synchroniser, glitch filter, edge select,
// hold-off timer, event strobe, sticky drop flag and an active-low LED stretcher.
module pulse_frontend #(
  parameter int NUM_INPUTS    = 8,
  parameter int SYNC_STAGES   = 2,
  parameter int FILTER_WIDTH  = 4,
  parameter int HOLDOFF_WIDTH = 8,
  parameter int LED_STRETCH   = 20
) (
  input  logic                     clki,
  input  logic                     rst,
  input  logic [NUM_INPUTS-1:0]    pulse_in,
  input  logic [NUM_INPUTS-1:0]    invert,
  input  logic [NUM_INPUTS-1:0]    enable,
  input  logic [1:0]               edge_mode,
  input  logic [FILTER_WIDTH-1:0]  min_width,
  input  logic [HOLDOFF_WIDTH-1:0] holdoff,
  input  logic                     clear_drops,
  output logic [NUM_INPUTS-1:0]    pulse_out,
  output logic [NUM_INPUTS-1:0]    level_out,
  output logic [NUM_INPUTS-1:0]    dropped,
  output logic [NUM_INPUTS-1:0]    activity_n
);

  typedef enum logic [1:0] {
    EDGE_RISE = 2'b00,
    EDGE_FALL = 2'b01,
    EDGE_BOTH = 2'b10,
    EDGE_NONE = 2'b11
  } edge_sel_e;

  localparam logic [FILTER_WIDTH-1:0]  GCNT_ONE = 1;
  localparam logic [HOLDOFF_WIDTH-1:0] HCNT_ONE = 1;
  localparam logic [LED_STRETCH-1:0]   LED_ONE  = 1;

  logic [NUM_INPUTS-1:0]    sync_q [SYNC_STAGES];
  logic [FILTER_WIDTH-1:0]  gcnt   [NUM_INPUTS];
  logic [HOLDOFF_WIDTH-1:0] hcnt   [NUM_INPUTS];
  logic [LED_STRETCH-1:0]   led_cnt[NUM_INPUTS];

  logic [NUM_INPUTS-1:0] s;
  logic [NUM_INPUTS-1:0] accept;
  logic [NUM_INPUTS-1:0] qualified;
  logic [NUM_INPUTS-1:0] fire;
  logic [NUM_INPUTS-1:0] suppress;

  assign s = sync_q[SYNC_STAGES-1];

  // The filter accepts a new level and the edge is qualified in the same cycle.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no latch is inferred.
    accept    = '0;
    qualified = '0;
    fire      = '0;
    suppress  = '0;
    for (int ch = 0; ch < NUM_INPUTS; ch++) begin
      accept[ch] = (s[ch] != level_out[ch]) && (gcnt[ch] == min_width);
      case (edge_sel_e'(edge_mode))
        EDGE_RISE: qualified[ch] = accept[ch] & s[ch];
        EDGE_FALL: qualified[ch] = accept[ch] & ~s[ch];
        EDGE_BOTH: qualified[ch] = accept[ch];
        default:   qualified[ch] = 1'b0;
      endcase
      fire[ch]     = qualified[ch] & enable[ch] & (hcnt[ch] == '0);
      suppress[ch] = qualified[ch] & enable[ch] & (hcnt[ch] != '0);
    end
  end

  always_comb begin
    activity_n = '1;
    for (int ch = 0; ch < NUM_INPUTS; ch++) begin
      activity_n[ch] = (led_cnt[ch] == '0);
    end
  end

  always_ff @(posedge clki or posedge rst) begin
    if (rst) begin
      // NOTE: the per-channel counter arrays are plain flops, not RAM, so they are reset like any other state.
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sync_q[i] <= '0;
      end
      for (int ch = 0; ch < NUM_INPUTS; ch++) begin
        gcnt[ch]    <= '0;
        hcnt[ch]    <= '0;
        led_cnt[ch] <= '0;
      end
      pulse_out <= '0;
      level_out <= '0;
      dropped   <= '0;
    end else begin
      // NOTE: non-blocking assignments so every stage samples the pre-edge value of its predecessor.
      sync_q[0] <= pulse_in ^ invert;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
      pulse_out <= fire;

      for (int ch = 0; ch < NUM_INPUTS; ch++) begin
        if (s[ch] == level_out[ch]) begin
          gcnt[ch] <= '0;
        end else if (accept[ch]) begin
          level_out[ch] <= s[ch];
          gcnt[ch]      <= '0;
        end else if (gcnt[ch] != '1) begin
          gcnt[ch] <= gcnt[ch] + GCNT_ONE;
        end

        // A suppressed edge leaves the running dead-time untouched.
        if (fire[ch]) begin
          hcnt[ch] <= holdoff;
        end else if (hcnt[ch] != '0) begin
          hcnt[ch] <= hcnt[ch] - HCNT_ONE;
        end

        if (suppress[ch]) begin
          dropped[ch] <= 1'b1;
        end else if (clear_drops) begin
          dropped[ch] <= 1'b0;
        end

        if (fire[ch]) begin
          led_cnt[ch] <= '1;
        end else if (led_cnt[ch] != '0) begin
          led_cnt[ch] <= led_cnt[ch] - LED_ONE;
        end
      end
    end
  end

endmodule

// File: tb/tb_pulse_frontend.sv
// Bench for pulse_frontend: vector table plus hand sequences; expected strobes go to a
// scoreboard keyed by cycle number and are compared by a per-cycle monitor.
module tb_pulse_frontend;

  localparam int N    = 8;
  localparam int SYNC = 2;
  localparam int FW   = 4;
  localparam int HW   = 8;
  localparam int LED  = 6;

  logic          clki;
  logic          rst;
  logic [N-1:0]  pulse_in;
  logic [N-1:0]  invert;
  logic [N-1:0]  enable;
  logic [1:0]    edge_mode;
  logic [FW-1:0] min_width;
  logic [HW-1:0] holdoff;
  logic          clear_drops;
  logic [N-1:0]  pulse_out;
  logic [N-1:0]  level_out;
  logic [N-1:0]  dropped;
  logic [N-1:0]  activity_n;

  pulse_frontend #(
    .NUM_INPUTS(N), .SYNC_STAGES(SYNC), .FILTER_WIDTH(FW),
    .HOLDOFF_WIDTH(HW), .LED_STRETCH(LED)
  ) dut (
    .clki(clki), .rst(rst), .pulse_in(pulse_in), .invert(invert), .enable(enable),
    .edge_mode(edge_mode), .min_width(min_width), .holdoff(holdoff),
    .clear_drops(clear_drops), .pulse_out(pulse_out), .level_out(level_out),
    .dropped(dropped), .activity_n(activity_n)
  );

  typedef struct {
    string        name;
    logic [N-1:0] hi;
    int           high;
    logic [1:0]   mode;
    logic [FW-1:0] mw;
    logic [N-1:0] inv;
    logic [N-1:0] en;
    logic [N-1:0] exp_start;
    logic [N-1:0] exp_end;
  } vec_t;

  typedef struct {
    int           cyc;
    logic [N-1:0] mask;
  } exp_t;

  exp_t sb[$];
  vec_t vecs[8];
  int   cyc;
  int   checks;
  int   errors;
  bit   mon_en;

  initial begin
    clki = 1'b0;
    forever #5 clki = ~clki;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push(input int c, input logic [N-1:0] m);
    exp_t e;
    e.cyc  = c;
    e.mask = m;
    sb.push_back(e);
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) @(negedge clki);
  endtask

  // Monitor: every cycle pulse_out must equal the OR of the strobes due in that cycle.
  initial cyc = 0;
  always @(posedge clki) begin
    logic [N-1:0] exp_mask;
    cyc++;
    #1;
    if (mon_en) begin
      exp_mask = '0;
      for (int i = sb.size() - 1; i >= 0; i--) begin
        if (sb[i].cyc == cyc) begin
          exp_mask |= sb[i].mask;
          sb.delete(i);
        end
      end
      check("pulse_out", 32'(pulse_out), 32'(exp_mask));
    end
  end

  task automatic apply_vec(input vec_t v);
    int c0;
    int lat;
    lat = SYNC + int'(v.mw) + 1;
    edge_mode = 2'b11;
    invert    = v.inv;
    enable    = v.en;
    min_width = v.mw;
    repeat (12) @(negedge clki);
    check({v.name, "_level_idle"}, 32'(level_out), 32'(v.inv));
    edge_mode = v.mode;
    repeat (2) @(negedge clki);
    c0 = cyc;
    pulse_in = v.hi;
    if (v.exp_start != '0) push(c0 + lat, v.exp_start);
    repeat (v.high) @(negedge clki);
    pulse_in = '0;
    c0 = cyc;
    if (v.exp_end != '0) push(c0 + lat, v.exp_end);
    repeat (12) @(negedge clki);
    check({v.name, "_dropped"}, 32'(dropped), 32'h0);
  endtask

  initial begin
    int c0;
    int low;
    checks = 0;
    errors = 0;
    mon_en = 1'b0;

    //             name           hi     high mode   mw    inv    en     start  end
    vecs[0] = '{"glitch3",     8'h02, 3, 2'b00, 4'd3, 8'h00, 8'hFF, 8'h00, 8'h00};
    vecs[1] = '{"glitch4",     8'h02, 4, 2'b00, 4'd3, 8'h00, 8'hFF, 8'h02, 8'h00};
    vecs[2] = '{"both_mw0",    8'h05, 2, 2'b10, 4'd0, 8'h00, 8'hFF, 8'h05, 8'h05};
    vecs[3] = '{"fall_mode",   8'h10, 5, 2'b01, 4'd1, 8'h00, 8'hFF, 8'h00, 8'h10};
    vecs[4] = '{"invert_fall", 8'h08, 5, 2'b01, 4'd1, 8'h08, 8'hFF, 8'h08, 8'h00};
    vecs[5] = '{"disabled",    8'h08, 5, 2'b01, 4'd1, 8'h08, 8'hF7, 8'h00, 8'h00};
    vecs[6] = '{"mode_none",   8'hFF, 6, 2'b11, 4'd2, 8'h00, 8'hFF, 8'h00, 8'h00};
    vecs[7] = '{"mixed_en",    8'hFF, 6, 2'b10, 4'd2, 8'h00, 8'h0F, 8'h0F, 8'h0F};

    rst         = 1'b0;
    pulse_in    = '0;
    invert      = '0;
    enable      = '1;
    edge_mode   = 2'b00;
    min_width   = 4'd3;
    holdoff     = '0;
    clear_drops = 1'b0;
    #1 rst = 1'b1;
    #1;
    check("rst_pulse_out",  32'(pulse_out),  32'h0);
    check("rst_level_out",  32'(level_out),  32'h0);
    check("rst_dropped",    32'(dropped),    32'h0);
    check("rst_activity_n", 32'(activity_n), 32'hFF);
    repeat (3) @(negedge clki);
    rst    = 1'b0;
    mon_en = 1'b1;
    repeat (10) @(negedge clki);

    // Latency: rise mode, min_width 3 -> strobe 6 cycles after the input edge
    c0 = cyc;
    pulse_in[0] = 1'b1;
    push(c0 + 6, 8'h01);
    wait_until(c0 + 5);
    check("latency_level_before", 32'(level_out[0]), 32'h0);
    wait_until(c0 + 6);
    check("latency_level_after", 32'(level_out[0]), 32'h1);
    wait_until(c0 + 10);
    pulse_in[0] = 1'b0;
    repeat (15) @(negedge clki);

    for (int i = 0; i < 8; i++) apply_vec(vecs[i]);

    // Hold-off: edges at t=0,4,12 with holdoff 10 -> events at 0 and 12, one drop
    edge_mode = 2'b11;
    invert    = '0;
    enable    = '1;
    min_width = 4'd1;
    holdoff   = 8'd10;
    repeat (12) @(negedge clki);
    edge_mode = 2'b10;
    repeat (2) @(negedge clki);
    c0 = cyc;
    pulse_in[2] = 1'b1;
    push(c0 + 4, 8'h04);
    wait_until(c0 + 4);
    pulse_in[2] = 1'b0;
    wait_until(c0 + 7);
    check("holdoff_drop_before", 32'(dropped), 32'h0);
    wait_until(c0 + 8);
    check("holdoff_drop_set", 32'(dropped), 32'h04);
    wait_until(c0 + 12);
    pulse_in[2] = 1'b1;
    push(c0 + 16, 8'h04);
    wait_until(c0 + 30);
    clear_drops = 1'b1;
    @(negedge clki);
    clear_drops = 1'b0;
    check("holdoff_drop_clear", 32'(dropped), 32'h0);

    // Clear coincident with a suppressed edge: the set wins
    c0 = cyc;
    pulse_in[2] = 1'b0;
    push(c0 + 4, 8'h04);
    wait_until(c0 + 4);
    pulse_in[2] = 1'b1;
    wait_until(c0 + 7);
    clear_drops = 1'b1;
    wait_until(c0 + 8);
    clear_drops = 1'b0;
    check("drop_set_wins", 32'(dropped), 32'h04);
    @(negedge clki);
    clear_drops = 1'b1;
    @(negedge clki);
    clear_drops = 1'b0;
    check("drop_clear_again", 32'(dropped), 32'h0);
    edge_mode = 2'b11;
    holdoff   = '0;
    pulse_in  = '0;
    repeat (20) @(negedge clki);

    // All channels at once, then the LED stretch length
    min_width = 4'd0;
    edge_mode = 2'b00;
    repeat (80) @(negedge clki);
    check("activity_idle", 32'(activity_n), 32'hFF);
    c0 = cyc;
    pulse_in = '1;
    push(c0 + 3, 8'hFF);
    wait_until(c0 + 2);
    check("activity_before", 32'(activity_n), 32'hFF);
    wait_until(c0 + 3);
    check("activity_all_low", 32'(activity_n), 32'h00);
    low = 1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clki);
      if (activity_n == '0) low++;
      else break;
    end
    check("activity_stretch_len", 32'(low), 32'((1 << LED) - 1));
    check("activity_release", 32'(activity_n), 32'hFF);

    // Reset in the middle of traffic
    mon_en    = 1'b0;
    holdoff   = 8'd5;
    edge_mode = 2'b10;
    pulse_in  = '0;
    repeat (15) begin
      @(negedge clki);
      pulse_in = 8'($urandom);
    end
    #2 rst = 1'b1;
    #1;
    check("midrst_pulse_out",  32'(pulse_out),  32'h0);
    check("midrst_level_out",  32'(level_out),  32'h0);
    check("midrst_dropped",    32'(dropped),    32'h0);
    check("midrst_activity_n", 32'(activity_n), 32'hFF);
    pulse_in = '0;
    repeat (3) @(negedge clki);
    sb.delete();
    rst    = 1'b0;
    mon_en = 1'b1;
    repeat (20) @(negedge clki);
    check("post_rst_level", 32'(level_out), 32'h0);
    check("post_rst_activity", 32'(activity_n), 32'hFF);
    check("scoreboard_drained", 32'(sb.size()), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
